// File: rtl/rf_bypass_param_pkg.sv
// Shared definitions for the parametrised bypassing register file: defaults,
// select-width helper, zero-register index and error-cause encoding.
package rf_bypass_param_pkg;

  localparam int unsigned DefaultWidth = 16;
  localparam int unsigned DefaultNreg  = 8;
  localparam int unsigned ZeroRegIdx   = 0;

  // Smallest select width able to address nreg registers (at least 1 bit).
  function automatic int unsigned sel_width(input int unsigned nreg);
    return (nreg <= 2) ? 1 : $clog2(nreg);
  endfunction

  typedef enum logic [1:0] {
    ErrNone      = 2'd0,
    ErrCollision = 2'd1,
    ErrWrRange   = 2'd2,
    ErrRsvRange  = 2'd3
  } err_cause_e;

endpackage

// File: rtl/rf_bypass_rdport.sv
// Combinational read port: register mux with optional same-cycle write bypass,
// zero-register forcing, out-of-range masking and busy masking.
module rf_bypass_rdport
  import rf_bypass_param_pkg::*;
#(
  parameter int unsigned WIDTH    = DefaultWidth,
  parameter int unsigned NREG     = DefaultNreg,
  parameter int unsigned SEL_W    = sel_width(DefaultNreg),
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic [WIDTH-1:0] regs_i [NREG],
  input  logic [NREG-1:0]  busy_i,
  input  logic             wr1_en_i,
  input  logic [SEL_W-1:0] wr1_sel_i,
  input  logic [WIDTH-1:0] wr1_data_i,
  input  logic             wr2_en_i,
  input  logic [SEL_W-1:0] wr2_sel_i,
  input  logic [WIDTH-1:0] wr2_data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             busy_o
);

  localparam int unsigned IdxW = sel_width(NREG);

  logic [IdxW-1:0] idx;
  logic            readable;
  logic            hit1;
  logic            hit2;

  always_comb begin
    idx      = sel_i[IdxW-1:0];
    readable = (32'(sel_i) < NREG) &&
               !((ZERO_REG != 0) && (sel_i == SEL_W'(ZeroRegIdx)));
    hit1     = (BYPASS != 0) && wr1_en_i && (wr1_sel_i == sel_i);
    hit2     = (BYPASS != 0) && wr2_en_i && (wr2_sel_i == sel_i);
    data_o   = '0;
    busy_o   = 1'b0;
    if (readable) begin
      data_o = regs_i[idx];
      busy_o = busy_i[idx];
      // Forwarded data is current, so the pending flag no longer applies.
      if (hit2) begin
        data_o = wr2_data_i;
        busy_o = 1'b0;
      end else if (hit1) begin
        data_o = wr1_data_i;
        busy_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rf_bypass_param.sv
// Parametrised two-read/two-write register file with optional write bypass,
// per-register pending scoreboard and sticky error flag.
module rf_bypass_param
  import rf_bypass_param_pkg::*;
#(
  parameter int unsigned WIDTH    = DefaultWidth,
  parameter int unsigned NREG     = DefaultNreg,
  parameter int unsigned SEL_W    = sel_width(DefaultNreg),
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] read1regsel,
  input  logic [SEL_W-1:0] read2regsel,
  output logic [WIDTH-1:0] read1data,
  output logic [WIDTH-1:0] read2data,
  output logic             read1busy,
  output logic             read2busy,
  input  logic             write1,
  input  logic [SEL_W-1:0] write1regsel,
  input  logic [WIDTH-1:0] write1data,
  input  logic             write2,
  input  logic [SEL_W-1:0] write2regsel,
  input  logic [WIDTH-1:0] write2data,
  input  logic             rsv,
  input  logic [SEL_W-1:0] rsvregsel,
  output logic             err
);

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [NREG-1:0]  busy_q, busy_d;
  logic             err_q, err_d;

  logic w1_oor, w2_oor, rsv_oor;
  logic w1_ok, w2_ok, rsv_ok;
  logic collide;

  always_comb begin
    w1_oor  = write1 && (32'(write1regsel) >= NREG);
    w2_oor  = write2 && (32'(write2regsel) >= NREG);
    rsv_oor = rsv && (32'(rsvregsel) >= NREG);
    // Register 0 accesses are silently dropped when it is hardwired.
    w1_ok   = write1 && !w1_oor &&
              !((ZERO_REG != 0) && (write1regsel == SEL_W'(ZeroRegIdx)));
    w2_ok   = write2 && !w2_oor &&
              !((ZERO_REG != 0) && (write2regsel == SEL_W'(ZeroRegIdx)));
    rsv_ok  = rsv && !rsv_oor &&
              !((ZERO_REG != 0) && (rsvregsel == SEL_W'(ZeroRegIdx)));
    collide = w1_ok && w2_ok && (write1regsel == write2regsel);

    regs_d = regs_q;
    busy_d = busy_q;
    for (int unsigned r = 0; r < NREG; r++) begin
      if (w1_ok && (write1regsel == SEL_W'(r))) begin
        regs_d[r] = write1data;
        busy_d[r] = 1'b0;
      end
      if (w2_ok && (write2regsel == SEL_W'(r))) begin
        regs_d[r] = write2data;
        busy_d[r] = 1'b0;
      end
      // A new reservation outranks a retiring write to the same register.
      if (rsv_ok && (rsvregsel == SEL_W'(r))) begin
        busy_d[r] = 1'b1;
      end
    end
    err_d = err_q | w1_oor | w2_oor | rsv_oor | collide;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;

  rf_bypass_rdport #(
    .WIDTH    (WIDTH),
    .NREG     (NREG),
    .SEL_W    (SEL_W),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_rdport1 (
    .sel_i      (read1regsel),
    .regs_i     (regs_q),
    .busy_i     (busy_q),
    .wr1_en_i   (write1),
    .wr1_sel_i  (write1regsel),
    .wr1_data_i (write1data),
    .wr2_en_i   (write2),
    .wr2_sel_i  (write2regsel),
    .wr2_data_i (write2data),
    .data_o     (read1data),
    .busy_o     (read1busy)
  );

  rf_bypass_rdport #(
    .WIDTH    (WIDTH),
    .NREG     (NREG),
    .SEL_W    (SEL_W),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_rdport2 (
    .sel_i      (read2regsel),
    .regs_i     (regs_q),
    .busy_i     (busy_q),
    .wr1_en_i   (write1),
    .wr1_sel_i  (write1regsel),
    .wr1_data_i (write1data),
    .wr2_en_i   (write2),
    .wr2_sel_i  (write2regsel),
    .wr2_data_i (write2data),
    .data_o     (read2data),
    .busy_o     (read2busy)
  );

endmodule

// File: tb/tb_rf_bypass_param.sv
// Bench for rf_bypass_param: three configurations (bypass, no bypass, zero-reg
// with NREG=6) share one stimulus stream and are checked against a register model.
module tb_rf_bypass_param;
  import rf_bypass_param_pkg::*;

  localparam int NCFG = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  r1s, r2s, w1s, w2s, rsvs;
  logic        w1, w2, rsv;
  logic [15:0] w1d, w2d;
  logic [15:0] rd1 [NCFG];
  logic [15:0] rd2 [NCFG];
  logic        rb1 [NCFG];
  logic        rb2 [NCFG];
  logic        erro [NCFG];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rf_bypass_param #(.WIDTH(16), .NREG(8), .SEL_W(3), .BYPASS(1), .ZERO_REG(0)) u_byp (
    .clk(clk), .rst(rst), .read1regsel(r1s), .read2regsel(r2s),
    .read1data(rd1[0]), .read2data(rd2[0]), .read1busy(rb1[0]), .read2busy(rb2[0]),
    .write1(w1), .write1regsel(w1s), .write1data(w1d),
    .write2(w2), .write2regsel(w2s), .write2data(w2d),
    .rsv(rsv), .rsvregsel(rsvs), .err(erro[0])
  );

  rf_bypass_param #(.WIDTH(16), .NREG(8), .SEL_W(3), .BYPASS(0), .ZERO_REG(0)) u_nobyp (
    .clk(clk), .rst(rst), .read1regsel(r1s), .read2regsel(r2s),
    .read1data(rd1[1]), .read2data(rd2[1]), .read1busy(rb1[1]), .read2busy(rb2[1]),
    .write1(w1), .write1regsel(w1s), .write1data(w1d),
    .write2(w2), .write2regsel(w2s), .write2data(w2d),
    .rsv(rsv), .rsvregsel(rsvs), .err(erro[1])
  );

  rf_bypass_param #(.WIDTH(16), .NREG(6), .SEL_W(3), .BYPASS(1), .ZERO_REG(1)) u_zero (
    .clk(clk), .rst(rst), .read1regsel(r1s), .read2regsel(r2s),
    .read1data(rd1[2]), .read2data(rd2[2]), .read1busy(rb1[2]), .read2busy(rb2[2]),
    .write1(w1), .write1regsel(w1s), .write1data(w1d),
    .write2(w2), .write2regsel(w2s), .write2data(w2d),
    .rsv(rsv), .rsvregsel(rsvs), .err(erro[2])
  );

  // ---------------- reference model ----------------
  logic [15:0] m_regs [NCFG][8];
  logic        m_busy [NCFG][8];
  logic        m_err [NCFG];
  err_cause_e  m_cause [NCFG];

  function automatic int nreg_of(input int c);
    return (c == 2) ? 6 : 8;
  endfunction

  function automatic bit byp_of(input int c);
    return c != 1;
  endfunction

  function automatic bit zr_of(input int c);
    return c == 2;
  endfunction

  function automatic bit wr_ok(input int c, input logic [2:0] s);
    return (int'(s) < nreg_of(c)) && !(zr_of(c) && s == 3'd0);
  endfunction

  function automatic void m_reset();
    for (int c = 0; c < NCFG; c++) begin
      for (int r = 0; r < 8; r++) begin
        m_regs[c][r] = '0;
        m_busy[c][r] = 1'b0;
      end
      m_err[c]   = 1'b0;
      m_cause[c] = ErrNone;
    end
  endfunction

  function automatic void m_read(input int c, input logic [2:0] s,
                                 output logic [15:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (wr_ok(c, s)) begin
      d = m_regs[c][s];
      b = m_busy[c][s];
      if (byp_of(c) && w2 && w2s == s) begin
        d = w2d;
        b = 1'b0;
      end else if (byp_of(c) && w1 && w1s == s) begin
        d = w1d;
        b = 1'b0;
      end
    end
  endfunction

  function automatic void m_step();
    for (int c = 0; c < NCFG; c++) begin
      bit ok1, ok2, okr;
      ok1 = w1 && wr_ok(c, w1s);
      ok2 = w2 && wr_ok(c, w2s);
      okr = rsv && wr_ok(c, rsvs);
      if ((w1 && int'(w1s) >= nreg_of(c)) || (w2 && int'(w2s) >= nreg_of(c))) begin
        m_err[c] = 1'b1;
        m_cause[c] = ErrWrRange;
      end
      if (rsv && int'(rsvs) >= nreg_of(c)) begin
        m_err[c] = 1'b1;
        m_cause[c] = ErrRsvRange;
      end
      if (ok1 && ok2 && w1s == w2s) begin
        m_err[c] = 1'b1;
        m_cause[c] = ErrCollision;
      end
      if (ok1) begin
        m_regs[c][w1s] = w1d;
        m_busy[c][w1s] = 1'b0;
      end
      if (ok2) begin
        m_regs[c][w2s] = w2d;
        m_busy[c][w2s] = 1'b0;
      end
      if (okr) m_busy[c][rsvs] = 1'b1;
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int c, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cfg%0d @%0t: got %h expected %h", name, c, $time, act, exp);
    end
  endtask

  task automatic idle();
    w1 = 1'b0; w1s = 3'd0; w1d = '0;
    w2 = 1'b0; w2s = 3'd0; w2d = '0;
    rsv = 1'b0; rsvs = 3'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_reset();
  endtask

  task automatic check_all();
    logic [15:0] d;
    logic b;
    for (int c = 0; c < NCFG; c++) begin
      m_read(c, r1s, d, b);
      chk("rd1", c, 32'(rd1[c]), 32'(d));
      chk("busy1", c, 32'(rb1[c]), 32'(b));
      m_read(c, r2s, d, b);
      chk("rd2", c, 32'(rd2[c]), 32'(d));
      chk("busy2", c, 32'(rb2[c]), 32'(b));
      chk($sformatf("err(%s)", m_cause[c].name()), c, 32'(erro[c]), 32'(m_err[c]));
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        w1;  logic [2:0] w1s; logic [15:0] w1d;
    logic        w2;  logic [2:0] w2s; logic [15:0] w2d;
    logic        rsv; logic [2:0] rsvs;
    logic [2:0]  r1s; logic [2:0] r2s;
    logic [15:0] d1_b; logic [15:0] d1_n;
    logic        b2_b; logic b2_n; logic err_e;
  } vec_t;

  vec_t vt [12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          w1    w1s   w1d       w2    w2s   w2d       rsv   rsvs  r1s   r2s
    //          d1_b      d1_n      b2_b  b2_n  err
    vt[0]  = '{1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd5, 3'd0,
               16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd5, 3'd0,
               16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 3'd5, 3'd4,
               16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd5, 3'd4,
               16'h1234, 16'h1234, 1'b1, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 3'd4, 16'h00FF, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd4, 3'd4,
               16'h00FF, 16'h0000, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd4, 3'd4,
               16'h00FF, 16'h00FF, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 3'd4, 16'h1111, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 3'd4, 3'd4,
               16'h1111, 16'h00FF, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd4, 3'd4,
               16'h1111, 16'h1111, 1'b1, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 3'd4, 3'd4,
               16'h1111, 16'h1111, 1'b1, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd4, 3'd4,
               16'h1111, 16'h1111, 1'b1, 1'b1, 1'b0};
    vt[10] = '{1'b1, 3'd2, 16'hAAAA, 1'b1, 3'd2, 16'h5555, 1'b0, 3'd0, 3'd2, 3'd4,
               16'h5555, 16'h0000, 1'b1, 1'b1, 1'b0};
    vt[11] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd2, 3'd4,
               16'h5555, 16'h5555, 1'b1, 1'b1, 1'b1};

    idle();
    r1s = 3'd0;
    r2s = 3'd0;
    m_reset();

    // Reset then sweep every select on all three configurations.
    do_reset();
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      r1s = 3'(s);
      r2s = 3'(7 - s);
      #2;
      for (int c = 0; c < NCFG; c++) begin
        chk("rst_rd1", c, 32'(rd1[c]), 32'h0);
        chk("rst_rd2", c, 32'(rd2[c]), 32'h0);
        chk("rst_busy1", c, 32'(rb1[c]), 32'h0);
        chk("rst_busy2", c, 32'(rb2[c]), 32'h0);
        chk("rst_err", c, 32'(erro[c]), 32'h0);
      end
    end

    // Reset asserted while a write to r3 is pending.
    @(negedge clk);
    w1 = 1'b1; w1s = 3'd3; w1d = 16'hBEEF; r1s = 3'd3;
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #2;
    for (int c = 0; c < NCFG; c++) chk("midrst_r3", c, 32'(rd1[c]), 32'h0);

    // Table-driven sequence: bypass vs no-bypass, scoreboard, collision.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      w1 = vt[k].w1; w1s = vt[k].w1s; w1d = vt[k].w1d;
      w2 = vt[k].w2; w2s = vt[k].w2s; w2d = vt[k].w2d;
      rsv = vt[k].rsv; rsvs = vt[k].rsvs;
      r1s = vt[k].r1s; r2s = vt[k].r2s;
      #2;
      chk($sformatf("vec%0d_rd1", k), 0, 32'(rd1[0]), 32'(vt[k].d1_b));
      chk($sformatf("vec%0d_rd1", k), 1, 32'(rd1[1]), 32'(vt[k].d1_n));
      chk($sformatf("vec%0d_busy2", k), 0, 32'(rb2[0]), 32'(vt[k].b2_b));
      chk($sformatf("vec%0d_busy2", k), 1, 32'(rb2[1]), 32'(vt[k].b2_n));
      chk($sformatf("vec%0d_err", k), 0, 32'(erro[0]), 32'(vt[k].err_e));
      chk($sformatf("vec%0d_err", k), 1, 32'(erro[1]), 32'(vt[k].err_e));
    end
    // err stays set until the next reset.
    @(negedge clk);
    idle();
    #2 chk("err_sticky", 0, 32'(erro[0]), 32'h1);

    // Zero register and out-of-range handling.
    do_reset();
    @(negedge clk);
    w1 = 1'b1; w1s = 3'd0; w1d = 16'hFFFF; rsv = 1'b1; rsvs = 3'd0; r1s = 3'd0;
    #2;
    chk("zr_byp_r0", 2, 32'(rd1[2]), 32'h0);
    chk("byp_r0", 0, 32'(rd1[0]), 32'hFFFF);
    @(negedge clk);
    idle();
    r1s = 3'd0;
    #2;
    chk("zr_r0", 2, 32'(rd1[2]), 32'h0);
    chk("zr_busy0", 2, 32'(rb1[2]), 32'h0);
    chk("zr_err", 2, 32'(erro[2]), 32'h0);
    chk("r0_val", 0, 32'(rd1[0]), 32'hFFFF);
    chk("r0_rsv_wins", 0, 32'(rb1[0]), 32'h1);
    @(negedge clk);
    w1 = 1'b1; w1s = 3'd7; w1d = 16'h1357;
    @(negedge clk);
    idle();
    r1s = 3'd6;
    r2s = 3'd7;
    #2;
    chk("oor_err", 2, 32'(erro[2]), 32'h1);
    chk("inrange_err", 0, 32'(erro[0]), 32'h0);
    chk("oor_rd6", 2, 32'(rd1[2]), 32'h0);
    chk("oor_busy6", 2, 32'(rb1[2]), 32'h0);
    chk("oor_rd7", 2, 32'(rd2[2]), 32'h0);
    chk("r7_val", 0, 32'(rd2[0]), 32'h1357);

    // Randomised traffic against the model, with periodic resets.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      w1 = 1'($urandom_range(0, 1)); w1s = 3'($urandom_range(0, 7));
      w1d = 16'($urandom);
      w2 = 1'($urandom_range(0, 1)); w2s = 3'($urandom_range(0, 7));
      w2d = 16'($urandom);
      rsv = 1'($urandom_range(0, 1)); rsvs = 3'($urandom_range(0, 7));
      r1s = 3'($urandom_range(0, 7));
      r2s = (i % 3 == 0) ? w1s : 3'($urandom_range(0, 7));
      if (i % 40 == 39) begin
        rst = 1'b1;
        m_reset();
        #2 check_all();
        @(posedge clk);
        #1 rst = 1'b0;
      end else begin
        #2 check_all();
        @(posedge clk);
        m_step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
